// File: rtl/coin_accumulator.sv
// coin_accumulator: front-end stage of the vending machine.
// Detects rising edges on the coin and button levels and keeps the 6-bit
// running credit. It runs purchases and refunds and pulses vend, change,
// reject and deny for one cycle each.
module coin_accumulator #(
    parameter logic [5:0] P_CANDY = 6'd15,
    parameter logic [5:0] P_DRINK = 6'd30,
    parameter logic [5:0] P_SNACK = 6'd60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       coin50,
    input  logic       buy_candy,
    input  logic       buy_drink,
    input  logic       buy_snack,
    input  logic       cancel,
    output logic [5:0] coin,
    output logic       vend,
    output logic [1:0] item,
    output logic [5:0] change,
    output logic       change_valid,
    output logic       reject,
    output logic       deny
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        VEND   = 2'd2,
        REFUND = 2'd3
    } state_t;

    state_t      state_r;
    logic [6:0]  prev_r;
    logic [5:0]  credit_r;
    logic        vend_r;
    logic [1:0]  item_r;
    logic [5:0]  change_r;
    logic        change_valid_r;
    logic        reject_r;
    logic        deny_r;

    // Bit order: {cancel, snack, drink, candy, coin50, coin10, coin5}
    logic [6:0]  level_s;
    logic [6:0]  edge_s;
    logic        any_coin_s;
    logic        coin_multi_s;
    logic [6:0]  coin_val_s;
    logic [6:0]  sum_s;
    logic        any_buy_s;
    logic [5:0]  price_s;
    logic [1:0]  code_s;

    assign level_s = {cancel, buy_snack, buy_drink, buy_candy, coin50, coin10, coin5};
    assign edge_s  = level_s & ~prev_r;

    // Decode the winning coin and buy edges and the widened credit sum.
    always_comb begin
        any_coin_s   = |edge_s[2:0];
        coin_multi_s = (edge_s[0] & edge_s[1]) | (edge_s[0] & edge_s[2]) |
                       (edge_s[1] & edge_s[2]);
        if (edge_s[2]) begin
            coin_val_s = 7'd50;
        end else if (edge_s[1]) begin
            coin_val_s = 7'd10;
        end else if (edge_s[0]) begin
            coin_val_s = 7'd5;
        end else begin
            coin_val_s = 7'd0;
        end
        sum_s = {1'b0, credit_r} + coin_val_s;

        any_buy_s = |edge_s[5:3];
        if (edge_s[5]) begin
            price_s = P_SNACK;
            code_s  = 2'd3;
        end else if (edge_s[4]) begin
            price_s = P_DRINK;
            code_s  = 2'd2;
        end else if (edge_s[3]) begin
            price_s = P_CANDY;
            code_s  = 2'd1;
        end else begin
            price_s = 6'd0;
            code_s  = 2'd0;
        end
    end

    // Main FSM: credit, edge history and all registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            prev_r         <= 7'd0;
            credit_r       <= 6'd0;
            vend_r         <= 1'b0;
            item_r         <= 2'd0;
            change_r       <= 6'd0;
            change_valid_r <= 1'b0;
            reject_r       <= 1'b0;
            deny_r         <= 1'b0;
        end else begin
            prev_r         <= level_s;
            vend_r         <= 1'b0;
            item_r         <= 2'd0;
            change_r       <= 6'd0;
            change_valid_r <= 1'b0;
            reject_r       <= 1'b0;
            deny_r         <= 1'b0;
            case (state_r)
                IDLE, HOLD: begin
                    if (edge_s[6]) begin
                        // Cancel wins; any coin arriving with it is refused.
                        reject_r <= any_coin_s;
                        if (state_r == HOLD) begin
                            state_r        <= REFUND;
                            change_r       <= credit_r;
                            change_valid_r <= 1'b1;
                        end
                    end else if (any_buy_s) begin
                        reject_r <= any_coin_s;
                        if (credit_r >= price_s) begin
                            state_r        <= VEND;
                            vend_r         <= 1'b1;
                            item_r         <= code_s;
                            change_r       <= credit_r - price_s;
                            change_valid_r <= (credit_r != price_s);
                        end else begin
                            deny_r <= 1'b1;
                        end
                    end else if (any_coin_s) begin
                        if (sum_s > 7'd63) begin
                            reject_r <= 1'b1;
                        end else begin
                            credit_r <= sum_s[5:0];
                            state_r  <= HOLD;
                            reject_r <= coin_multi_s;
                        end
                    end
                end
                VEND, REFUND: begin
                    // Transaction done: edges seen now are discarded.
                    credit_r <= 6'd0;
                    state_r  <= IDLE;
                end
                default: begin
                    credit_r <= 6'd0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign coin         = credit_r;
    assign vend         = vend_r;
    assign item         = item_r;
    assign change       = change_r;
    assign change_valid = change_valid_r;
    assign reject       = reject_r;
    assign deny         = deny_r;

endmodule

// File: tb/tb_coin_accumulator.sv
// Self-checking bench for coin_accumulator: directed vector table,
// reset corner cases and randomized traffic against a behavioural model.
module tb_coin_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin5 = 1'b0, coin10 = 1'b0, coin50 = 1'b0;
    logic       buy_candy = 1'b0, buy_drink = 1'b0, buy_snack = 1'b0, cancel = 1'b0;
    logic [5:0] coin;
    logic       vend;
    logic [1:0] item;
    logic [5:0] change;
    logic       change_valid;
    logic       reject;
    logic       deny;

    int checks = 0;
    int failures = 0;

    // Input encoding: bit0 coin5, bit1 coin10, bit2 coin50, bit3 candy,
    // bit4 drink, bit5 snack, bit6 cancel.
    localparam logic [6:0] C5 = 7'h01, C10 = 7'h02, C50 = 7'h04, CANDY = 7'h08,
                           DRINK = 7'h10, SNACK = 7'h20, CANCEL = 7'h40, NONE = 7'h00;

    coin_accumulator dut (
        .clk(clk), .rst_n(rst_n),
        .coin5(coin5), .coin10(coin10), .coin50(coin50),
        .buy_candy(buy_candy), .buy_drink(buy_drink), .buy_snack(buy_snack),
        .cancel(cancel),
        .coin(coin), .vend(vend), .item(item), .change(change),
        .change_valid(change_valid), .reject(reject), .deny(deny)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int       m_credit;
    bit       m_busy;
    bit [6:0] m_prev;
    int       e_vend, e_item, e_change, e_cv, e_rej, e_deny;

    typedef struct {
        logic [6:0] in;
        int coin, vend, item, change, cv, rej, deny;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_busy = 0; m_prev = 7'd0;
        e_vend = 0; e_item = 0; e_change = 0; e_cv = 0; e_rej = 0; e_deny = 0;
    endtask

    // One clock of the vending rules, written directly from the prose.
    task automatic model_step(input bit [6:0] in);
        bit [6:0] e;
        int price, code, ncoins, val;
        e = in & ~m_prev;
        m_prev = in;
        e_vend = 0; e_item = 0; e_change = 0; e_cv = 0; e_rej = 0; e_deny = 0;
        ncoins = int'(e[0]) + int'(e[1]) + int'(e[2]);
        if (m_busy) begin
            m_credit = 0;
            m_busy = 0;
        end else if (e[6]) begin
            if (ncoins > 0) e_rej = 1;
            if (m_credit > 0) begin
                e_cv = 1; e_change = m_credit; m_busy = 1;
            end
        end else if (e[5] || e[4] || e[3]) begin
            if (ncoins > 0) e_rej = 1;
            if (e[5]) begin price = 60; code = 3; end
            else if (e[4]) begin price = 30; code = 2; end
            else begin price = 15; code = 1; end
            if (m_credit >= price) begin
                e_vend = 1; e_item = code; m_busy = 1;
                if (m_credit - price != 0) begin
                    e_cv = 1; e_change = m_credit - price;
                end
            end else begin
                e_deny = 1;
            end
        end else if (ncoins > 0) begin
            val = e[2] ? 50 : (e[1] ? 10 : 5);
            if (ncoins > 1) e_rej = 1;
            if (m_credit + val > 63) e_rej = 1;
            else m_credit = m_credit + val;
        end
    endtask

    task automatic drive(input logic [6:0] in);
        {cancel, buy_snack, buy_drink, buy_candy, coin50, coin10, coin5} = in;
    endtask

    // Apply one cycle, advance the model and compare every output to it.
    task automatic cycle(input logic [6:0] in);
        drive(in);
        @(posedge clk);
        model_step(in);
        #1;
        chk("coin", int'(coin), m_credit);
        chk("vend", int'(vend), e_vend);
        chk("item", int'(item), e_item);
        chk("change", int'(change), e_change);
        chk("change_valid", int'(change_valid), e_cv);
        chk("reject", int'(reject), e_rej);
        chk("deny", int'(deny), e_deny);
    endtask

    task automatic add(input logic [6:0] in, input int c, input int v, input int it,
                       input int ch, input int cv, input int rj, input int dn);
        vec_t t;
        t.in = in; t.coin = c; t.vend = v; t.item = it; t.change = ch;
        t.cv = cv; t.rej = rj; t.deny = dn;
        vecs.push_back(t);
    endtask

    initial begin
        // Directed vectors: {in, coin, vend, item, change, cv, reject, deny}
        add(C10, 10,0,0,0,0,0,0);  add(NONE, 10,0,0,0,0,0,0); add(NONE, 10,0,0,0,0,0,0);
        add(C5, 15,0,0,0,0,0,0);   add(NONE, 15,0,0,0,0,0,0);
        add(CANDY, 15,1,1,0,0,0,0); add(NONE, 0,0,0,0,0,0,0);
        add(C50, 50,0,0,0,0,0,0);  add(NONE, 50,0,0,0,0,0,0);
        add(C10, 60,0,0,0,0,0,0);  add(NONE, 60,0,0,0,0,0,0);
        add(DRINK, 60,1,2,30,1,0,0); add(NONE, 0,0,0,0,0,0,0);
        add(C50, 50,0,0,0,0,0,0);  add(NONE, 50,0,0,0,0,0,0);
        add(C10, 60,0,0,0,0,0,0);  add(NONE, 60,0,0,0,0,0,0);
        add(C5, 60,0,0,0,0,1,0);   add(NONE, 60,0,0,0,0,0,0);
        add(SNACK, 60,1,3,0,0,0,0); add(NONE, 0,0,0,0,0,0,0);
        add(C10, 10,0,0,0,0,0,0);  add(NONE, 10,0,0,0,0,0,0);
        add(C10, 20,0,0,0,0,0,0);  add(NONE, 20,0,0,0,0,0,0);
        add(C5, 25,0,0,0,0,0,0);   add(NONE, 25,0,0,0,0,0,0);
        add(DRINK, 25,0,0,0,0,0,1); add(NONE, 25,0,0,0,0,0,0);
        add(CANCEL, 25,0,0,25,1,0,0); add(NONE, 0,0,0,0,0,0,0);
        add(C5|C50, 50,0,0,0,0,1,0); add(NONE, 50,0,0,0,0,0,0);
        add(C10, 60,0,0,0,0,0,0);  add(NONE, 60,0,0,0,0,0,0);
        add(CANCEL|SNACK, 60,0,0,60,1,0,0); add(NONE, 0,0,0,0,0,0,0);
        for (int i = 0; i < 5; i++) add(C10, 10,0,0,0,0,0,0);
        add(NONE, 10,0,0,0,0,0,0);
        add(CANCEL, 10,0,0,10,1,0,0); add(NONE, 0,0,0,0,0,0,0);
        add(C5, 5,0,0,0,0,0,0); add(C10, 15,0,0,0,0,0,0); add(C5, 20,0,0,0,0,0,0);
        add(NONE, 20,0,0,0,0,0,0);
        add(C10|CANCEL, 20,0,0,20,1,1,0); add(NONE, 0,0,0,0,0,0,0);
        add(CANCEL, 0,0,0,0,0,0,0); add(DRINK, 0,0,0,0,0,0,1);

        // Reset state
        model_reset();
        #12;
        chk("rst_coin", int'(coin), 0);
        chk("rst_pulses", int'({vend, change_valid, reject, deny}), 0);
        chk("rst_item_change", int'({item, change}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].in);
            chk($sformatf("v%0d_coin", i), int'(coin), vecs[i].coin);
            chk($sformatf("v%0d_vend", i), int'(vend), vecs[i].vend);
            chk($sformatf("v%0d_item", i), int'(item), vecs[i].item);
            chk($sformatf("v%0d_change", i), int'(change), vecs[i].change);
            chk($sformatf("v%0d_cv", i), int'(change_valid), vecs[i].cv);
            chk($sformatf("v%0d_reject", i), int'(reject), vecs[i].rej);
            chk($sformatf("v%0d_deny", i), int'(deny), vecs[i].deny);
        end

        // Reset asserted mid-VEND clears outputs asynchronously.
        cycle(NONE); cycle(C50); cycle(NONE); cycle(C10); cycle(NONE);
        cycle(DRINK);
        chk("pre_rst_vend", int'(vend), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_vend", int'(vend), 0);
        chk("async_coin", int'(coin), 0);
        chk("async_change", int'({change_valid, change}), 0);
        model_reset();
        // A level held high through reset release counts as an edge.
        drive(C10);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(C10);
        chk("held_thru_reset", int'(coin), 10);
        cycle(NONE); cycle(CANCEL); cycle(NONE);

        // Reset asserted mid-REFUND.
        cycle(C5); cycle(NONE); cycle(CANCEL);
        chk("pre_rst_cv", int'(change_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_refund", int'({change_valid, change, coin}), 0);
        model_reset();
        drive(NONE);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [6:0] r;
            for (int b = 0; b < 6; b++) r[b] = ($urandom_range(0, 3) == 0);
            r[6] = ($urandom_range(0, 15) == 0);
            cycle(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
